// File: rtl/mips_pkg.sv
// Definitions shared by the MIPS front end: fetch FSM states, opcodes, reset PC.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          WAIT_W           = 8;

    // Word offset from a 16-bit branch immediate, as a 32-bit byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc.sv
// Next-PC selection: jump beats taken branch beats sequential; all mod 2^32.
module next_pc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        jump,
    input  logic        pcsrc,
    output logic [31:0] pc_plus4,
    output logic [31:0] npc
);

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        npc = pc_plus4;
        if (jump)
            npc = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (pcsrc)
            npc = pc_plus4 + branch_offset(instr[15:0]);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, handshakes with imem, holds the word for decode.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemRdata,
    input  logic        Advance,
    input  logic        Jump,
    input  logic        PCSrc,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        Fault
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    fetch_state_t      state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic [31:0]       pc_q, instr_q, npc;

    next_pc u_next_pc (
        .pc       (pc_q),
        .instr    (instr_q),
        .jump     (Jump),
        .pcsrc    (PCSrc),
        .pc_plus4 (PCPlus4),
        .npc      (npc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  state_d = ST_REQ;
            ST_REQ: begin
                if (ImemAck)                    state_d = ST_HOLD;
                else if (wait_cnt == WAIT_LAST) state_d = ST_FAULT;
            end
            ST_HOLD:  if (Advance) state_d = ST_REQ;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // PC only moves on a retiring HOLD cycle, so Jump/PCSrc are only sampled there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            wait_cnt <= '0;
        end else begin
            if (state_q == ST_REQ) begin
                if (ImemAck) begin
                    instr_q  <= ImemRdata;
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
            if (state_q == ST_HOLD && Advance)
                pc_q <= npc;
        end
    end

    // Status outputs decode the state flop directly, so they carry no input path.
    always_comb begin
        ImemReq    = (state_q == ST_REQ);
        InstrValid = (state_q == ST_HOLD);
        Fault      = (state_q == ST_FAULT);
    end

    assign ImemAddr = pc_q;
    assign PC       = pc_q;
    assign Instr    = instr_q;

endmodule
